// File: rtl/rv_pkg.sv
// Shared RV32I core definitions.
// Holds the datapath width, register count, register-address width and the
// register-address type used by the register file and its neighbours.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : rv_pkg

// File: rtl/rv_register_file.sv
// RV32I integer register file.
// Purpose: 32 x XLEN architectural registers with two combinational read
//          ports (rs1/rs2) and one synchronous write port (rd). x0 reads as 0.
// Ports:
//   clk   - clock, state updates on rising edge
//   rst_n - asynchronous active-low reset, clears every register
//   we3   - write enable, port 3
//   a1    - read address, port 1 (rs1)
//   a2    - read address, port 2 (rs2)
//   a3    - write address, port 3 (rd)
//   wd3   - write data, port 3
//   rd1   - read data, port 1
//   rd2   - read data, port 2
// No write-to-read bypass: a read of the register being written returns the
// old value until the clock edge. Forwarding belongs to the hazard unit.
module rv_register_file
    import rv_pkg::*;
#(
    parameter int unsigned XLEN_P  = XLEN,
    parameter int unsigned NREGS_P = NREGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we3,
    input  reg_addr_t         a1,
    input  reg_addr_t         a2,
    input  reg_addr_t         a3,
    input  logic [XLEN_P-1:0] wd3,
    output logic [XLEN_P-1:0] rd1,
    output logic [XLEN_P-1:0] rd2
);

    logic [XLEN_P-1:0] regs_q [NREGS_P];
    logic [XLEN_P-1:0] regs_d [NREGS_P];

    // Writes to x0 are dropped so the entry stays at its reset value of 0.
    always_comb begin
        for (int i = 0; i < int'(NREGS_P); i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we3 && (a3 != '0)) begin
            regs_d[a3] = wd3;
        end
    end

    // Async reset dominates the clock, so writes are blocked while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS_P); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREGS_P); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rd1 = (a1 == '0) ? '0 : regs_q[a1];
        rd2 = (a2 == '0) ? '0 : regs_q[a2];
    end

endmodule : rv_register_file

// File: tb/tb_rv_register_file.sv
// Directed testbench for rv_register_file.
module tb_rv_register_file;
    import rv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        we3;
    reg_addr_t   a1;
    reg_addr_t   a2;
    reg_addr_t   a3;
    logic [31:0] wd3;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int n_checks;
    int n_errors;

    rv_register_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we3   (we3),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one write across a single rising edge, inputs changed on negedges.
    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        we3 = 1'b1;
        a3  = addr;
        wd3 = data;
        @(negedge clk);
        we3 = 1'b0;
    endtask

    task automatic read_both(input logic [4:0] addr);
        a1 = addr;
        a2 = addr;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b1;
        we3   = 1'b0;
        a1    = '0;
        a2    = '0;
        a3    = '0;
        wd3   = '0;

        // Reset pulse not aligned to the clock; reads need no edge.
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 32; k++) begin
            read_both(5'(k));
            check($sformatf("reset_rd1_x%0d", k), rd1, 32'h0);
            check($sformatf("reset_rd2_x%0d", k), rd2, 32'h0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;

        // x0 ignores writes.
        write_reg(5'd0, 32'h12153524);
        read_both(5'd0);
        check("x0_rd1", rd1, 32'h0);
        check("x0_rd2", rd2, 32'h0);

        // x1 write, others untouched.
        write_reg(5'd1, 32'hC0895E81);
        read_both(5'd1);
        check("x1_rd1", rd1, 32'hC0895E81);
        check("x1_rd2", rd2, 32'hC0895E81);
        for (int k = 2; k < 32; k++) begin
            read_both(5'(k));
            check($sformatf("x1_other_x%0d", k), rd1, 32'h0);
        end

        // x31 write, then disabled write must not change it.
        write_reg(5'd31, 32'h8484D609);
        read_both(5'd31);
        check("x31_rd1", rd1, 32'h8484D609);
        check("x31_rd2", rd2, 32'h8484D609);
        @(negedge clk);
        we3 = 1'b0;
        a3  = 5'd31;
        wd3 = 32'hFFFFFFFF;
        @(negedge clk);
        check("x31_we0_rd1", rd1, 32'h8484D609);

        // Same-cycle read/write: old value before edge, new after.
        write_reg(5'd5, 32'hAAAAAAAA);
        a1  = 5'd5;
        we3 = 1'b1;
        a3  = 5'd5;
        wd3 = 32'h55555555;
        #1;
        check("rw_before_edge", rd1, 32'hAAAAAAAA);
        @(posedge clk);
        #1;
        check("rw_after_edge", rd1, 32'h55555555);
        @(negedge clk);
        we3 = 1'b0;

        // Dual port, distinct addresses.
        write_reg(5'd7, 32'h1);
        write_reg(5'd8, 32'h2);
        a1 = 5'd7;
        a2 = 5'd8;
        #1;
        check("dual_rd1", rd1, 32'h1);
        check("dual_rd2", rd2, 32'h2);

        // Reset mid-operation.
        write_reg(5'd3, 32'hDEADBEEF);
        a1 = 5'd3;
        a2 = 5'd1;
        #1;
        check("x3_pre_reset", rd1, 32'hDEADBEEF);
        #1 rst_n = 1'b0;
        #1;
        check("x3_async_clear", rd1, 32'h0);
        check("x1_async_clear", rd2, 32'h0);
        we3 = 1'b1;
        a3  = 5'd3;
        wd3 = 32'h12345678;
        @(posedge clk);
        #1;
        check("write_in_reset", rd1, 32'h0);
        @(negedge clk);
        we3 = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("x3_after_release", rd1, 32'h0);

        // Normal writes work again after reset release.
        write_reg(5'd3, 32'hCAFEF00D);
        read_both(5'd3);
        check("x3_post_reset_write", rd2, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_rv_register_file
